// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings,
// stage-count helper and saturation constants.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDS = 2'b10,
        OP_SUBS = 2'b11
    } op_e;

    // Helpers return a wide vector; callers size-cast down to their own WIDTH.
    localparam int SAT_W_MAX = 256;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic logic [SAT_W_MAX-1:0] SAT_MAX(input int width);
        return (SAT_W_MAX'(1) << (width - 1)) - SAT_W_MAX'(1);
    endfunction

    function automatic logic [SAT_W_MAX-1:0] SAT_MIN(input int width);
        return SAT_W_MAX'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_if.sv
// Operand-issue and result-writeback handshake bundle for addsub_pipe.
interface addsub_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    import addsub_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_n;
    logic             out_z;
    logic             out_c;
    logic             out_v;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_n, out_z, out_c, out_v, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_n, out_z, out_c, out_v, out_tag, busy
    );

endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells; also
// exposes the carry into the top bit so the last stage can derive overflow.
module addsub_chunk
    import addsub_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);
    logic [CHUNK:0] w_c;

    assign w_c[0] = cin;

    for (genvar j = 0; j < CHUNK; j++) begin : g_fa
        assign sum[j]   = a[j] ^ b[j] ^ w_c[j];
        assign w_c[j+1] = (a[j] & b[j]) | (w_c[j] & (a[j] ^ b[j]));
    end

    assign cout = w_c[CHUNK];
    assign cmsb = w_c[CHUNK-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: one CHUNK-bit slice of the carry chain per stage,
// with a single global advance so the whole pipe moves or holds together.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 4
) (
    input logic     clk,
    input logic     rst_n,
    addsub_if.slave bus
);
    localparam int STAGES = calc_stages(WIDTH, CHUNK);
    localparam int LAST   = STAGES - 1;
    localparam logic [WIDTH-1:0] C_SAT_MAX = WIDTH'(SAT_MAX(WIDTH));
    localparam logic [WIDTH-1:0] C_SAT_MIN = WIDTH'(SAT_MIN(WIDTH));

    if (WIDTH % CHUNK != 0) begin : g_bad_cfg
        $fatal(1, "addsub_pipe: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic             r_cy  [STAGES];
    op_e              r_op  [STAGES];
    logic [TAG_W-1:0] r_tag [STAGES];
    logic             r_n, r_z, r_c, r_v;

    logic             w_vld_in  [STAGES];
    logic [WIDTH-1:0] w_a_in    [STAGES];
    logic [WIDTH-1:0] w_b_in    [STAGES];
    logic [WIDTH-1:0] w_sum_in  [STAGES];
    logic [WIDTH-1:0] w_sum_nxt [STAGES];
    logic             w_cy_in   [STAGES];
    logic             w_cout    [STAGES];
    logic             w_cmsb    [STAGES];
    op_e              w_op_in   [STAGES];
    logic [TAG_W-1:0] w_tag_in  [STAGES];
    logic [CHUNK-1:0] w_csum    [STAGES];

    logic             w_adv;
    logic             w_sub0;
    logic             w_v;
    logic             w_sat;
    logic             w_busy;
    logic [WIDTH-1:0] w_res;

    assign w_adv  = !bus.out_valid || bus.out_ready;
    assign w_sub0 = (op_e'(bus.in_op) == OP_SUB) || (op_e'(bus.in_op) == OP_SUBS);

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_src
            assign w_vld_in[i] = bus.in_valid;
            assign w_a_in[i]   = bus.in_a;
            assign w_b_in[i]   = bus.in_b ^ {WIDTH{w_sub0}};
            assign w_cy_in[i]  = w_sub0;
            assign w_sum_in[i] = '0;
            assign w_op_in[i]  = op_e'(bus.in_op);
            assign w_tag_in[i] = bus.in_tag;
        end else begin : g_src
            assign w_vld_in[i] = r_vld[i-1];
            assign w_a_in[i]   = r_a[i-1];
            assign w_b_in[i]   = r_b[i-1];
            assign w_cy_in[i]  = r_cy[i-1];
            assign w_sum_in[i] = r_sum[i-1];
            assign w_op_in[i]  = r_op[i-1];
            assign w_tag_in[i] = r_tag[i-1];
        end

        addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a    (w_a_in[i][i*CHUNK +: CHUNK]),
            .b    (w_b_in[i][i*CHUNK +: CHUNK]),
            .cin  (w_cy_in[i]),
            .sum  (w_csum[i]),
            .cout (w_cout[i]),
            .cmsb (w_cmsb[i])
        );

        // Bits above the current slice are still zero, so OR-ing merges cleanly.
        assign w_sum_nxt[i] = w_sum_in[i] | (WIDTH'(w_csum[i]) << (i * CHUNK));
    end

    // Overflow always clamps toward A's sign, for both add and subtract.
    assign w_v   = w_cmsb[LAST] ^ w_cout[LAST];
    assign w_sat = w_v && ((w_op_in[LAST] == OP_ADDS) || (w_op_in[LAST] == OP_SUBS));
    assign w_res = !w_sat ? w_sum_nxt[LAST]
                          : (w_a_in[LAST][WIDTH-1] ? C_SAT_MIN : C_SAT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_vld[i] <= 1'b0;
                r_sum[i] <= '0;
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_cy[i]  <= 1'b0;
                r_op[i]  <= OP_ADD;
                r_tag[i] <= '0;
            end
            r_n <= 1'b0;
            r_z <= 1'b0;
            r_c <= 1'b0;
            r_v <= 1'b0;
        end else if (w_adv) begin
            for (int i = 0; i < LAST; i++) begin
                r_vld[i] <= w_vld_in[i];
                r_sum[i] <= w_sum_nxt[i];
                r_a[i]   <= w_a_in[i];
                r_b[i]   <= w_b_in[i];
                r_cy[i]  <= w_cout[i];
                r_op[i]  <= w_op_in[i];
                r_tag[i] <= w_tag_in[i];
            end
            r_vld[LAST] <= w_vld_in[LAST];
            r_sum[LAST] <= w_res;
            r_tag[LAST] <= w_tag_in[LAST];
            r_n         <= w_res[WIDTH-1];
            r_z         <= (w_res == '0);
            r_c         <= w_cout[LAST];
            r_v         <= w_v;
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            w_busy = w_busy | r_vld[i];
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld[LAST];
    assign bus.out_res   = r_sum[LAST];
    assign bus.out_tag   = r_tag[LAST];
    assign bus.out_n     = r_n;
    assign bus.out_z     = r_z;
    assign bus.out_c     = r_c;
    assign bus.out_v     = r_v;
    assign bus.busy      = w_busy;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (32-bit, 8-bit chunks): directed corner
// cases, stall/reset behaviour and a randomised sweep against an arithmetic model.
module tb_addsub_pipe;
    import addsub_pkg::*;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int TAG_W = 4;
    localparam int LAT   = WIDTH / CHUNK;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  nzcv;
        logic [3:0]  tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    addsub_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    addsub_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: exact signed arithmetic in 64 bits, then wrap / clamp.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] op, input logic [3:0] tag);
        exp_t        e;
        longint      sa, sb_, exact;
        logic [32:0] s33;
        logic [31:0] res;
        logic        c, v;
        sa    = longint'($signed(a));
        sb_   = longint'($signed(b));
        exact = op[0] ? (sa - sb_) : (sa + sb_);
        s33   = {1'b0, a} + {1'b0, b};
        c     = op[0] ? (a >= b) : s33[32];
        v     = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
        res   = op[0] ? (a - b) : (a + b);
        if (op[1] && v) res = (exact > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        e.res  = res;
        e.nzcv = {res[31], res == 32'd0, c, v};
        e.tag  = tag;
        return e;
    endfunction

    // Caller must be in the low clock phase; returns just after the next rising edge.
    task automatic cycle(input bit vld, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [3:0] tag, input bit rdy,
                         output bit acc);
        bus.in_valid  = vld;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_op     = op;
        bus.in_tag    = tag;
        bus.out_ready = rdy;
        #1;
        acc = vld && bus.in_ready;
        if (acc) sb.push_back(model(a, b, op, tag));
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", bus.out_valid, 0);
            end else begin
                check("res",  bus.out_res, sb[0].res);
                check("nzcv", {bus.out_n, bus.out_z, bus.out_c, bus.out_v}, sb[0].nzcv);
                check("tag",  bus.out_tag, sb[0].tag);
                if (!rdy) check("stall_in_ready", bus.in_ready, 0);
                else      void'(sb.pop_front());
            end
        end
        @(posedge clk);
    endtask

    task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] e_res, input logic [3:0] e_nzcv);
        int         lat;
        logic [3:0] tg;
        tg = 4'($urandom_range(0, 15));
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_op     = op;
        bus.in_tag    = tg;
        bus.out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({name, "_latency"}, lat, LAT);
        check({name, "_res"}, bus.out_res, e_res);
        check({name, "_nzcv"}, {bus.out_n, bus.out_z, bus.out_c, bus.out_v}, e_nzcv);
        check({name, "_tag"}, bus.out_tag, tg);
        @(posedge clk);
    endtask

    logic [31:0] corner [7] = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE};

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 6)];
        return $urandom();
    endfunction

    initial begin
        bit          acc;
        bit          pend;
        bit          armed;
        int          sent;
        int          stall_left;
        logic [31:0] pa, pb;
        logic [1:0]  pop;
        logic [3:0]  ptag;
        logic [31:0] a6 [6];
        logic [31:0] b6 [6];
        logic [1:0]  op6 [6];

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = 2'b00;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_res", bus.out_res, 0);
        check("rst_out_tag", bus.out_tag, 0);
        check("rst_flags", {bus.out_n, bus.out_z, bus.out_c, bus.out_v}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);

        // Directed arithmetic corners (nzcv = {n,z,c,v}).
        run_one("add_small",   OP_ADD,  32'h0000_0021, 32'h0000_0022, 32'h0000_0043, 4'b0000);
        run_one("sub_equal",   OP_SUB,  32'h336F_B7E5, 32'h336F_B7E5, 32'h0000_0000, 4'b0110);
        run_one("add_ripple",  OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
        run_one("add_ovf",     OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
        run_one("adds_sat",    OP_ADDS, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0001);
        run_one("subs_sat",    OP_SUBS, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 4'b1011);
        run_one("sub_ovf",     OP_SUB,  32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 4'b1001);

        // Six back-to-back beats with a three-cycle output stall.
        for (int i = 0; i < 6; i++) begin
            a6[i]  = pick();
            b6[i]  = pick();
            op6[i] = 2'($urandom_range(0, 3));
        end
        sb.delete();
        sent       = 0;
        armed      = 1'b1;
        stall_left = 0;
        for (int cyc = 0; cyc < 60 && !(sent == 6 && sb.size() == 0); cyc++) begin
            int idx;
            @(negedge clk);
            if (armed && bus.out_valid) begin
                armed      = 1'b0;
                stall_left = 3;
            end
            idx = (sent < 6) ? sent : 0;
            cycle(sent < 6, a6[idx], b6[idx], op6[idx], 4'(sent), stall_left == 0, acc);
            if (stall_left > 0) stall_left--;
            if (acc) sent++;
        end
        check("b2b_sent", sent, 6);
        check("b2b_drained", sb.size(), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cycle(1'b0, '0, '0, 2'b00, '0, 1'b1, acc);
        end
        check("b2b_idle_busy", bus.busy, 0);

        // Reset with work in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cycle(1'b1, pick(), pick(), 2'($urandom_range(0, 3)), 4'(i), 1'b1, acc);
        end
        @(negedge clk);
        cycle(1'b0, '0, '0, 2'b00, '0, 1'b0, acc);
        #3;
        check("rstmid_valid_before", bus.out_valid, 1);
        check("rstmid_busy_before", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", bus.out_valid, 0);
        check("rstmid_busy", bus.busy, 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rstmid_quiet", bus.out_valid, 0);
            cycle(1'b0, '0, '0, 2'b00, '0, 1'b1, acc);
        end
        run_one("post_rst", OP_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b1000);

        // Randomised sweep with randomised backpressure; pending beats are held until taken.
        sb.delete();
        sent = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 60000 && (sent < 10000 || sb.size() != 0); cyc++) begin
            @(negedge clk);
            if (!pend && sent < 10000 && $urandom_range(0, 9) < 8) begin
                pa   = pick();
                pb   = ($urandom_range(0, 9) == 0) ? pa : pick();
                pop  = 2'($urandom_range(0, 3));
                ptag = 4'($urandom_range(0, 15));
                pend = 1'b1;
            end
            cycle(pend, pa, pb, pop, ptag, $urandom_range(0, 9) < 7, acc);
            if (acc) begin
                pend = 1'b0;
                sent++;
            end
        end
        check("sweep_sent", sent, 10000);
        check("sweep_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
